// File: rtl/lc3_chk_pkg.sv
// Shared types and helpers for the LC-3 run-time checker: rule indices,
// checker FSM states and the expected condition-code function.
package lc3_chk_pkg;

  localparam int NUM_RULES = 6;

  typedef enum logic [2:0] {
    R_PC_RST     = 3'd0,
    R_BUS_CONT   = 3'd1,
    R_NZP_ONEHOT = 3'd2,
    R_NZP_VALUE  = 3'd3,
    R_PC_WDOG    = 3'd4,
    R_PC_INC     = 3'd5
  } rule_e;

  typedef enum logic [1:0] {
    CHK_RST = 2'd0,
    RUN     = 2'd1,
    HALT    = 2'd2
  } chk_state_e;

  // Expected {N,Z,P} for a bus value of the given width (value zero-extended).
  function automatic logic [2:0] nzp_of(input logic [63:0] value, input int width);
    if (value[width-1]) return 3'b100;
    if (value == 64'd0) return 3'b010;
    return 3'b001;
  endfunction

endpackage

// File: rtl/lc3_chk_watchdog.sv
// PC-load watchdog: counts cycles without a kick, saturates at TIMEOUT and
// reports expiry once; another kick is needed before it can fire again.
module lc3_chk_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic kick,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_reg;
  logic          armed_reg;

  assign expire = en && armed_reg && !kick && (cnt_reg == CW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      armed_reg <= 1'b1;
    end else if (en) begin
      if (kick) begin
        cnt_reg   <= '0;
        armed_reg <= 1'b1;
      end else begin
        if (cnt_reg != CW'(TIMEOUT)) cnt_reg <= cnt_reg + CW'(1);
        if (expire) armed_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lc3_runtime_checker.sv
// Run-time protocol checker for the LC-3 datapath: evaluates six rules each
// cycle and keeps sticky flags, a saturating count and first-error capture.
module lc3_runtime_checker
  import lc3_chk_pkg::*;
#(
  parameter int             DATA_W      = 16,
  parameter logic [DATA_W-1:0] PC_RESET = '0,
  parameter int             TIMEOUT     = 64,
  parameter int             ERR_CNT_W   = 8,
  parameter int             CYC_W       = 32,
  parameter int             HALT_ON_ERR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_err,
  input  logic                 enaMARM,
  input  logic                 enaPC,
  input  logic                 enaMDR,
  input  logic                 enaALU,
  input  logic                 ldPC,
  input  logic [1:0]           selPC,
  input  logic                 flagWE,
  input  logic                 N,
  input  logic                 Z,
  input  logic                 P,
  input  logic [DATA_W-1:0]    Buss,
  input  logic [DATA_W-1:0]    PCOut,
  output logic [NUM_RULES-1:0] err_vec,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [2:0]           first_err_id,
  output logic [CYC_W-1:0]     first_err_cyc,
  output logic                 halted
);

  chk_state_e           state_reg;
  logic [CYC_W-1:0]     cyc_reg;
  logic                 flags_valid_reg;
  logic                 flagwe_d_reg;
  logic [DATA_W-1:0]    buss_d_reg;
  logic                 pcinc_d_reg;
  logic [DATA_W-1:0]    pc_d_reg;
  logic [DATA_W-1:0]    pc_inc;
  logic [NUM_RULES-1:0] viol;
  logic [2:0]           low_id;
  logic                 any_viol;
  logic                 wd_expire;

  lc3_chk_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .en     (state_reg != HALT),
    .kick   (ldPC),
    .expire (wd_expire)
  );

  assign pc_inc   = pc_d_reg + DATA_W'(1);
  assign any_viol = |viol;

  always_comb begin
    viol = '0;
    case (state_reg)
      CHK_RST: viol[int'(R_PC_RST)] = (PCOut != PC_RESET);
      RUN: begin
        viol[int'(R_BUS_CONT)]   = ($countones({enaMARM, enaPC, enaMDR, enaALU}) > 1);
        viol[int'(R_NZP_ONEHOT)] = flags_valid_reg && !$onehot({N, Z, P});
        viol[int'(R_NZP_VALUE)]  = flagwe_d_reg && ({N, Z, P} != nzp_of(64'(buss_d_reg), DATA_W));
        viol[int'(R_PC_WDOG)]    = wd_expire;
        viol[int'(R_PC_INC)]     = pcinc_d_reg && (PCOut != pc_inc);
      end
      default: viol = '0;
    endcase
  end

  always_comb begin
    low_id = 3'd0;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (viol[i]) low_id = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= CHK_RST;
      cyc_reg         <= '0;
      flags_valid_reg <= 1'b0;
      flagwe_d_reg    <= 1'b0;
      buss_d_reg      <= '0;
      pcinc_d_reg     <= 1'b0;
      pc_d_reg        <= '0;
      err_vec         <= '0;
      err_pulse       <= 1'b0;
      err_count       <= '0;
      first_err_id    <= '0;
      first_err_cyc   <= '0;
      halted          <= 1'b0;
    end else begin
      if (state_reg != HALT) begin
        cyc_reg      <= cyc_reg + CYC_W'(1);
        flagwe_d_reg <= flagWE;
        buss_d_reg   <= Buss;
        pcinc_d_reg  <= ldPC && (selPC == 2'd0);
        pc_d_reg     <= PCOut;
        if (flagWE) flags_valid_reg <= 1'b1;
      end else begin
        // A resume must not compare against history captured before the halt.
        flagwe_d_reg <= 1'b0;
        pcinc_d_reg  <= 1'b0;
      end

      err_pulse <= 1'b0;
      if (clr_err) begin
        err_vec       <= '0;
        err_count     <= '0;
        first_err_id  <= '0;
        first_err_cyc <= '0;
        halted        <= 1'b0;
        state_reg     <= RUN;
      end else begin
        if (any_viol) begin
          err_vec   <= err_vec | viol;
          err_pulse <= 1'b1;
          if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
          if (err_vec == '0) begin
            first_err_id  <= low_id;
            first_err_cyc <= cyc_reg;
          end
        end
        case (state_reg)
          CHK_RST: state_reg <= RUN;
          RUN: begin
            if ((HALT_ON_ERR != 0) && any_viol) begin
              state_reg <= HALT;
              halted    <= 1'b1;
            end
          end
          default: state_reg <= HALT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lc3_runtime_checker.sv
// Directed scoreboard bench for lc3_runtime_checker (free-running and halt-on-error instances).
module tb_lc3_runtime_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr_err, enaMARM, enaPC, enaMDR, enaALU, ldPC, flagWE, N, Z, P;
  logic [1:0]  selPC;
  logic [15:0] Buss, PCOut;

  logic [5:0]  d0_vec, d1_vec;
  logic        d0_pulse, d1_pulse, d0_halt, d1_halt;
  logic [7:0]  d0_cnt, d1_cnt;
  logic [2:0]  d0_id, d1_id;
  logic [31:0] d0_cyc, d1_cyc;

  lc3_runtime_checker #(
    .DATA_W(16), .PC_RESET(16'h0000), .TIMEOUT(8), .ERR_CNT_W(8), .CYC_W(32), .HALT_ON_ERR(0)
  ) dut (
    .clk(clk), .rst(rst), .clr_err(clr_err),
    .enaMARM(enaMARM), .enaPC(enaPC), .enaMDR(enaMDR), .enaALU(enaALU),
    .ldPC(ldPC), .selPC(selPC), .flagWE(flagWE), .N(N), .Z(Z), .P(P),
    .Buss(Buss), .PCOut(PCOut),
    .err_vec(d0_vec), .err_pulse(d0_pulse), .err_count(d0_cnt),
    .first_err_id(d0_id), .first_err_cyc(d0_cyc), .halted(d0_halt)
  );

  lc3_runtime_checker #(
    .DATA_W(16), .PC_RESET(16'h0000), .TIMEOUT(8), .ERR_CNT_W(8), .CYC_W(32), .HALT_ON_ERR(1)
  ) dut_h (
    .clk(clk), .rst(rst), .clr_err(clr_err),
    .enaMARM(enaMARM), .enaPC(enaPC), .enaMDR(enaMDR), .enaALU(enaALU),
    .ldPC(ldPC), .selPC(selPC), .flagWE(flagWE), .N(N), .Z(Z), .P(P),
    .Buss(Buss), .PCOut(PCOut),
    .err_vec(d1_vec), .err_pulse(d1_pulse), .err_count(d1_cnt),
    .first_err_id(d1_id), .first_err_cyc(d1_cyc), .halted(d1_halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [5:0]  vec;
    logic        pulse;
    logic [7:0]  cnt;
    logic [2:0]  id;
    logic [31:0] cyc;
    logic        halted;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  bit   use_h = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic compare(input exp_t e, input bit h);
    chk({e.tag, ".err_vec"},       h ? 32'(d1_vec)   : 32'(d0_vec),   32'(e.vec));
    chk({e.tag, ".err_pulse"},     h ? 32'(d1_pulse) : 32'(d0_pulse), 32'(e.pulse));
    chk({e.tag, ".err_count"},     h ? 32'(d1_cnt)   : 32'(d0_cnt),   32'(e.cnt));
    chk({e.tag, ".first_err_id"},  h ? 32'(d1_id)    : 32'(d0_id),    32'(e.id));
    chk({e.tag, ".first_err_cyc"}, h ? d1_cyc        : d0_cyc,        e.cyc);
    chk({e.tag, ".halted"},        h ? 32'(d1_halt)  : 32'(d0_halt),  32'(e.halted));
  endtask

  // Push the expected post-edge outputs, advance one clock, pop and compare.
  task automatic step(input string tag, input logic [5:0] vec, input logic pulse,
                      input logic [7:0] cnt, input logic [2:0] id,
                      input logic [31:0] cyc, input logic halted);
    exp_t e;
    e.tag = tag; e.vec = vec; e.pulse = pulse; e.cnt = cnt;
    e.id = id; e.cyc = cyc; e.halted = halted;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    $display("%s: dut%0d vec=%b pulse=%b cnt=%0d id=%0d cyc=%0d halted=%b", e.tag, use_h,
             use_h ? d1_vec : d0_vec, use_h ? d1_pulse : d0_pulse, use_h ? d1_cnt : d0_cnt,
             use_h ? d1_id : d0_id, use_h ? d1_cyc : d0_cyc, use_h ? d1_halt : d0_halt);
    compare(e, use_h);
  endtask

  task automatic check_zero(input string tag, input bit h);
    exp_t e;
    e.tag = tag; e.vec = '0; e.pulse = 1'b0; e.cnt = '0;
    e.id = '0; e.cyc = '0; e.halted = 1'b0;
    $display("%s: async check dut%0d", tag, h);
    compare(e, h);
  endtask

  task automatic idle_inputs();
    clr_err = 1'b0; enaMARM = 1'b0; enaPC = 1'b0; enaMDR = 1'b0; enaALU = 1'b0;
    ldPC = 1'b1; selPC = 2'd1; flagWE = 1'b0;
    N = 1'b0; Z = 1'b1; P = 1'b0; Buss = 16'h0000;
  endtask

  task automatic do_reset(input logic [15:0] pc);
    idle_inputs();
    PCOut = pc;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    PCOut = 16'h0000;
    #1 rst = 1'b1;
    #1;
    check_zero("reset_state", 1'b0);
    check_zero("reset_state_h", 1'b1);

    // R0: PC value on the first cycle after reset release
    do_reset(16'h0000);
    step("pc_rst_ok", 6'h00, 1'b0, 8'd0, 3'd0, 32'd0, 1'b0);
    do_reset(16'h3000);
    step("pc_rst_bad", 6'h01, 1'b1, 8'd1, 3'd0, 32'd0, 1'b0);
    PCOut = 16'h0000;
    step("pc_rst_hold", 6'h01, 1'b0, 8'd1, 3'd0, 32'd0, 1'b0);

    // R1: bus contention for three cycles, then clear racing a live error
    do_reset(16'h0000);
    step("bus_idle", 6'h00, 1'b0, 8'd0, 3'd0, 32'd0, 1'b0);
    enaPC = 1'b1; enaALU = 1'b1;
    step("bus_c1", 6'h02, 1'b1, 8'd1, 3'd1, 32'd1, 1'b0);
    step("bus_c2", 6'h02, 1'b1, 8'd2, 3'd1, 32'd1, 1'b0);
    step("bus_c3", 6'h02, 1'b1, 8'd3, 3'd1, 32'd1, 1'b0);
    clr_err = 1'b1;
    step("clr_wins", 6'h00, 1'b0, 8'd0, 3'd0, 32'd0, 1'b0);
    clr_err = 1'b0; enaPC = 1'b0; enaALU = 1'b0;
    step("after_clr", 6'h00, 1'b0, 8'd0, 3'd0, 32'd0, 1'b0);

    // R3 / R2: condition code value and one-hot checks
    do_reset(16'h0000);
    step("nzp_c0", 6'h00, 1'b0, 8'd0, 3'd0, 32'd0, 1'b0);
    flagWE = 1'b1; Buss = 16'h8001; {N, Z, P} = 3'b010;
    step("nzp_we_neg", 6'h00, 1'b0, 8'd0, 3'd0, 32'd0, 1'b0);
    flagWE = 1'b0; Buss = 16'h0000;
    step("nzp_bad_val", 6'h08, 1'b1, 8'd1, 3'd3, 32'd2, 1'b0);
    flagWE = 1'b1; Buss = 16'h8001; {N, Z, P} = 3'b100;
    step("nzp_we_neg2", 6'h08, 1'b0, 8'd1, 3'd3, 32'd2, 1'b0);
    flagWE = 1'b0; Buss = 16'h0000;
    step("nzp_good_n", 6'h08, 1'b0, 8'd1, 3'd3, 32'd2, 1'b0);
    flagWE = 1'b1; Buss = 16'h0005;
    step("nzp_we_pos", 6'h08, 1'b0, 8'd1, 3'd3, 32'd2, 1'b0);
    flagWE = 1'b0; Buss = 16'h0000; {N, Z, P} = 3'b001;
    step("nzp_good_p", 6'h08, 1'b0, 8'd1, 3'd3, 32'd2, 1'b0);
    flagWE = 1'b1; Buss = 16'h0000;
    step("nzp_we_zero", 6'h08, 1'b0, 8'd1, 3'd3, 32'd2, 1'b0);
    flagWE = 1'b0; {N, Z, P} = 3'b010;
    step("nzp_good_z", 6'h08, 1'b0, 8'd1, 3'd3, 32'd2, 1'b0);
    {N, Z, P} = 3'b011;
    step("nzp_not_onehot", 6'h0C, 1'b1, 8'd2, 3'd3, 32'd2, 1'b0);
    {N, Z, P} = 3'b010;
    step("nzp_recover", 6'h0C, 1'b0, 8'd2, 3'd3, 32'd2, 1'b0);

    // R4: watchdog with TIMEOUT=8, fires once per expiry
    do_reset(16'h0000);
    ldPC = 1'b0;
    for (int k = 0; k < 8; k++) step("wdog_quiet", 6'h00, 1'b0, 8'd0, 3'd0, 32'd0, 1'b0);
    step("wdog_fire", 6'h10, 1'b1, 8'd1, 3'd4, 32'd8, 1'b0);
    for (int k = 9; k <= 20; k++) step("wdog_once", 6'h10, 1'b0, 8'd1, 3'd4, 32'd8, 1'b0);
    ldPC = 1'b1;
    step("wdog_kick", 6'h10, 1'b0, 8'd1, 3'd4, 32'd8, 1'b0);
    ldPC = 1'b0;
    for (int k = 0; k < 8; k++) step("wdog_rearm", 6'h10, 1'b0, 8'd1, 3'd4, 32'd8, 1'b0);
    step("wdog_fire2", 6'h10, 1'b1, 8'd2, 3'd4, 32'd8, 1'b0);
    ldPC = 1'b1;

    // R5: PC increment after ldPC with selPC=0, including wrap
    do_reset(16'h0000);
    step("pcinc_c0", 6'h00, 1'b0, 8'd0, 3'd0, 32'd0, 1'b0);
    PCOut = 16'h3000; selPC = 2'd0;
    step("pcinc_ld", 6'h00, 1'b0, 8'd0, 3'd0, 32'd0, 1'b0);
    PCOut = 16'h3001; selPC = 2'd1;
    step("pcinc_ok", 6'h00, 1'b0, 8'd0, 3'd0, 32'd0, 1'b0);
    PCOut = 16'hFFFF; selPC = 2'd0;
    step("pcinc_ld_ffff", 6'h00, 1'b0, 8'd0, 3'd0, 32'd0, 1'b0);
    PCOut = 16'h0000; selPC = 2'd1;
    step("pcinc_wrap_ok", 6'h00, 1'b0, 8'd0, 3'd0, 32'd0, 1'b0);
    PCOut = 16'hFFFF; selPC = 2'd0;
    step("pcinc_ld_ffff2", 6'h00, 1'b0, 8'd0, 3'd0, 32'd0, 1'b0);
    PCOut = 16'h0002; selPC = 2'd1;
    step("pcinc_bad", 6'h20, 1'b1, 8'd1, 3'd5, 32'd6, 1'b0);
    PCOut = 16'h0003;
    step("pcinc_hold", 6'h20, 1'b0, 8'd1, 3'd5, 32'd6, 1'b0);

    // Halt-on-error instance: freeze, clear/resume, then async reset mid-halt
    use_h = 1'b1;
    do_reset(16'h0000);
    step("halt_c0", 6'h00, 1'b0, 8'd0, 3'd0, 32'd0, 1'b0);
    enaPC = 1'b1; enaALU = 1'b1; selPC = 2'd0; PCOut = 16'h0010;
    step("halt_trig_r1", 6'h02, 1'b1, 8'd1, 3'd1, 32'd1, 1'b1);
    enaPC = 1'b0; enaALU = 1'b0; selPC = 2'd1; ldPC = 1'b0; PCOut = 16'h0050;
    step("halt_r5_masked", 6'h02, 1'b0, 8'd1, 3'd1, 32'd1, 1'b1);
    enaMARM = 1'b1; enaMDR = 1'b1;
    step("halt_frozen", 6'h02, 1'b0, 8'd1, 3'd1, 32'd1, 1'b1);
    enaMARM = 1'b0; enaMDR = 1'b0; ldPC = 1'b1; clr_err = 1'b1;
    step("halt_clr", 6'h00, 1'b0, 8'd0, 3'd0, 32'd0, 1'b0);
    clr_err = 1'b0; enaPC = 1'b1; enaMDR = 1'b1;
    step("halt_resume_err", 6'h02, 1'b1, 8'd1, 3'd1, 32'd2, 1'b1);
    enaPC = 1'b0; enaMDR = 1'b0;
    step("halt_again", 6'h02, 1'b0, 8'd1, 3'd1, 32'd2, 1'b1);
    rst = 1'b1;
    #2;
    check_zero("async_rst_h", 1'b1);
    check_zero("async_rst", 1'b0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/lc3_runtime_checker.md
Name: lc3_runtime_checker

Overview:
- Synthesizable, parametrised run-time checker for the LC-3 datapath; the next generation of the team's assertion-only checker.
- Sits beside the CPU core, observes datapath control and status signals, and evaluates six protocol rules every cycle.
- Records violations in sticky error flags, a saturating counter and a first-error capture register, so errors are visible on silicon/FPGA as well as in simulation.
- Optional halt mode freezes all capture when the first error occurs.

Parameters:
- DATA_W, 16, datapath/bus/PC width.
- PC_RESET, 16'h0000, required PCOut value on the first cycle after reset release.
- TIMEOUT, 64, max consecutive cycles without ldPC before the watchdog fires (≥2).
- ERR_CNT_W, 8, error counter width (saturates).
- CYC_W, 32, cycle timestamp width (wraps).
- HALT_ON_ERR, 0, 1 = freeze all capture after the first error.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- clr_err  in  1  synchronous clear of error state; resumes from HALT
- enaMARM, enaPC, enaMDR, enaALU  in  1 each  bus tri-state enables
- ldPC  in  1  PC load strobe
- selPC  in  2  PC mux select; 0 = PC+1
- flagWE  in  1  NZP write enable
- N, Z, P  in  1 each  condition codes
- Buss  in  DATA_W  shared bus value
- PCOut  in  DATA_W  PC register value
- err_vec  out  6  sticky per-rule error flags
- err_pulse  out  1  high for the cycle in which any new violation is registered
- err_count  out  ERR_CNT_W  total violation-cycles, saturating
- first_err_id  out  3  index of the lowest rule failing in the first error cycle
- first_err_cyc  out  CYC_W  cycle stamp of the first error
- halted  out  1  high in HALT state

Behaviour:
- Reset: all outputs 0; cycle counter 0; state CHK_RST; watchdog 0; flags_valid 0.
- Cycle counter: increments every clock outside HALT; wraps.
- Rules: detected combinationally in cycle t, registered at edge t+1, visible at t+1.
  - R0 PC_RST: in CHK_RST (first edge after rst falls), PCOut != PC_RESET.
  - R1 BUS_CONT: more than one of enaMARM/enaPC/enaMDR/enaALU high.
  - R2 NZP_ONEHOT: flags_valid and {N,Z,P} not exactly one-hot. flags_valid is set one cycle after the first flagWE.
  - R3 NZP_VALUE: cycle after flagWE, NZP must match the registered Buss: MSB set → N; all zero → Z; otherwise P.
  - R4 PC_WDOG: watchdog reaches TIMEOUT with no ldPC. Counter clears on ldPC and saturates at TIMEOUT. The rule fires once per expiry: re-arm requires an ldPC.
  - R5 PC_INC: cycle after (ldPC && selPC==0), PCOut must equal the registered PCOut + 1 mod 2^DATA_W. FFFF→0000 is legal.
- FSM:
  - CHK_RST: evaluate R0 only → RUN.
  - RUN: evaluate R1–R5 → HALT if HALT_ON_ERR and any error.
  - HALT: no updates; halted=1 → RUN on clr_err.
- Error recording:
  - Any rule failing → set its err_vec bit; err_pulse=1; err_count += 1 (one increment per cycle regardless of how many rules fail), saturating at all-ones.
  - first_err_id and first_err_cyc are written only when err_vec was all-zero before the cycle.
- clr_err:
  - Clears err_vec, err_count, first_err_*, and halted.
  - Does not clear the cycle counter, flags_valid or watchdog.
  - Simultaneous with a new error: the clear wins and the error is dropped.
- rst mid-operation: immediate asynchronous return to reset values; the next release re-runs CHK_RST.
- During rst high, no rule is evaluated.

Decomposition:
- Package lc3_chk_pkg:
  - rule index enum (R_PC_RST=0 … R_PC_INC=5) and NUM_RULES=6;
  - state enum {CHK_RST, RUN, HALT};
  - function nzp_of(value) returning the expected 3-bit NZP.
- One sub-module, lc3_chk_watchdog: parametrised TIMEOUT counter with clear/saturate/expire-once logic.

Test Plan:
- Release rst with PCOut=16'h0000 → err_vec=0. Repeat with PCOut=16'h3000 → err_vec[0]=1, first_err_id=0, first_err_cyc=0, err_count=1.
- enaPC=enaALU=1 for 3 cycles → err_vec[1]=1, err_count=3, err_pulse high 3 cycles.
- flagWE with Buss=16'h8001, next cycle NZP=010 → err_vec[3]=1. With NZP=100 → no error. After that, NZP=011 → err_vec[2]=1.
- TIMEOUT=8, hold ldPC=0 → err_vec[4] set at cycle 8, err_count=1 through cycle 20. Pulse ldPC, then idle 8 more cycles → err_count=2.
- PCOut=16'hFFFF, ldPC with selPC=0, next PCOut=16'h0000 → no error. Next PCOut=16'h0002 instead → err_vec[5]=1.
- HALT_ON_ERR=1: trigger R1, then R5 → halted=1, err_vec only bit1, count frozen. Pulse clr_err → all cleared, halted=0, cycle counter continues. Assert rst mid-HALT → all outputs 0 asynchronously.
